// File: rtl/giraffe_uart_packer_if.sv
// Packer-side bundle of ADC capture inputs, UART handshake and status flags.
// drop_cnt exists only when GIRAFFE_PACKER_DROPCNT_EN is defined.
interface giraffe_uart_packer_if #(
    parameter int N_BIT  = 6,
    parameter int N_DATA = 8,
    parameter int N_CH   = 2
);
    logic [N_CH-1:0]   adc_ack;
    logic [N_BIT-1:0]  dout_adc;
    logic              uart_rdy;
    logic              wreq;
    logic [N_DATA-1:0] wdata;
    logic              fifo_full;
    logic              ovf;
`ifdef GIRAFFE_PACKER_DROPCNT_EN
    logic [7:0]        drop_cnt;

    modport master (
        input  adc_ack, dout_adc, uart_rdy,
        output wreq, wdata, fifo_full, ovf, drop_cnt
    );
    modport slave (
        output adc_ack, dout_adc, uart_rdy,
        input  wreq, wdata, fifo_full, ovf, drop_cnt
    );
`else
    modport master (
        input  adc_ack, dout_adc, uart_rdy,
        output wreq, wdata, fifo_full, ovf
    );
    modport slave (
        output adc_ack, dout_adc, uart_rdy,
        input  wreq, wdata, fifo_full, ovf
    );
`endif
endinterface

// File: rtl/giraffe_uart_packer.sv
// Captures tagged ADC results into a FIFO and frames them as UART bytes (MSB byte first).
// Optional saturating drop counter enabled by GIRAFFE_PACKER_DROPCNT_EN.
module giraffe_uart_packer #(
    parameter int N_BIT      = 6,
    parameter int N_DATA     = 8,
    parameter int N_CH       = 2,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    giraffe_uart_packer_if.master bus
);
    localparam int W     = TAG_W + N_BIT;
    localparam int NB    = (W + N_DATA - 1) / N_DATA;
    localparam int FW    = NB * N_DATA;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    logic [N_CH-1:0]   ack_d_r;
    logic [N_CH-1:0]   rise_s;
    logic              event_s;
    logic [TAG_W-1:0]  chan_s;

    logic [W-1:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [FW-1:0]     head_ext_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [FW-1:0]     shreg_r;
    logic [FW-1:0]     shreg_nxt_s;
    logic [BC_W-1:0]   bcnt_r;
    logic [BC_W-1:0]   bcnt_nxt_s;
    logic              gap_r;
    logic              gap_nxt_s;

    logic              wreq_r;
    logic [N_DATA-1:0] wdata_r;
    logic              fifo_full_r;
    logic              ovf_r;

    // Rising-edge detect; highest newly asserted channel wins the tag
    always_comb begin
        rise_s  = bus.adc_ack & ~ack_d_r;
        event_s = |rise_s;
        chan_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rise_s[i]) begin
                chan_s = TAG_W'(i);
            end else begin
                chan_s = chan_s;
            end
        end
    end

    // FIFO control; a pop on the same edge frees a slot for a push into a full FIFO
    always_comb begin
        full_s  = (count_r == CNT_W'(FIFO_DEPTH));
        empty_s = (count_r == '0);
        pop_s   = (state_r == ST_LOAD) && !empty_s;
        push_s  = event_s && (!full_s || pop_s);
        drop_s  = event_s && full_s && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        head_ext_s           = '0;
        head_ext_s[W-1:0]    = mem_r[rd_ptr_r];
    end

    // Acknowledge history register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_d_r <= '0;
        end else begin
            ack_d_r <= bus.adc_ack;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {chan_s, bus.dout_adc};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Framing FSM next-state and datapath
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        bcnt_nxt_s  = bcnt_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && bus.uart_rdy) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shreg_nxt_s = head_ext_s;
                bcnt_nxt_s  = BC_W'(NB - 1);
                state_nxt_s = ST_SEND;
            end
            ST_SEND: begin
                gap_nxt_s   = 1'b0;
                state_nxt_s = ST_GAP;
            end
            // Two dead cycles let the UART drop its ready before it is sampled
            ST_GAP: begin
                if (gap_r) begin
                    gap_nxt_s   = 1'b0;
                    state_nxt_s = ST_WAIT;
                end else begin
                    gap_nxt_s   = 1'b1;
                    state_nxt_s = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (bus.uart_rdy) begin
                    if (bcnt_r != '0) begin
                        shreg_nxt_s = shreg_r << N_DATA;
                        bcnt_nxt_s  = bcnt_r - BC_W'(1);
                        state_nxt_s = ST_SEND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, shift register and byte counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            bcnt_r  <= '0;
            gap_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shreg_r <= shreg_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    // Registered outputs; wdata is only refreshed when a byte is launched
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wreq_r      <= 1'b0;
            wdata_r     <= '0;
            fifo_full_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            wreq_r      <= (state_nxt_s == ST_SEND);
            if (state_nxt_s == ST_SEND) begin
                wdata_r <= shreg_nxt_s[FW-1 -: N_DATA];
            end
            fifo_full_r <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
            ovf_r       <= ovf_r | drop_s;
        end
    end

    assign bus.wreq      = wreq_r;
    assign bus.wdata     = wdata_r;
    assign bus.fifo_full = fifo_full_r;
    assign bus.ovf       = ovf_r;

`ifdef GIRAFFE_PACKER_DROPCNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating count of dropped samples
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_giraffe_uart_packer.sv
// Directed bench: default instance (NB=1) and a 12-bit instance (NB=2) on a shared clock/reset.
module tb_giraffe_uart_packer;
    logic clk;
    logic nrst;
    int   n_run;
    int   n_fail;
    int   cyc;

    logic [7:0] byte_q0[$];
    logic [7:0] byte_q1[$];

    giraffe_uart_packer_if #(.N_BIT(6),  .N_DATA(8), .N_CH(2)) bus0 ();
    giraffe_uart_packer_if #(.N_BIT(12), .N_DATA(8), .N_CH(2)) bus1 ();

    giraffe_uart_packer #(.N_BIT(6), .N_DATA(8), .N_CH(2), .TAG_W(2), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .nrst(nrst), .bus(bus0)
    );
    giraffe_uart_packer #(.N_BIT(12), .N_DATA(8), .N_CH(2), .TAG_W(2), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .nrst(nrst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.wreq === 1'b1) byte_q0.push_back(bus0.wdata);
        if (bus1.wreq === 1'b1) byte_q1.push_back(bus1.wdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base0;
        int base1;
        int t1;
        int seen;
        bit got;

        n_run = 0; n_fail = 0; cyc = 0;
        nrst = 1'b0;
        bus0.adc_ack = 2'b00; bus0.dout_adc = 6'h00;  bus0.uart_rdy = 1'b1;
        bus1.adc_ack = 2'b00; bus1.dout_adc = 12'h000; bus1.uart_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wreq",  32'(bus0.wreq), 32'd0);
        check("rst_wdata", 32'(bus0.wdata), 32'd0);
        check("rst_full",  32'(bus0.fifo_full), 32'd0);
        check("rst_ovf",   32'(bus0.ovf), 32'd0);
`ifdef GIRAFFE_PACKER_DROPCNT_EN
        check("rst_dropcnt", 32'(bus0.drop_cnt), 32'd0);
`endif
        nrst = 1'b1;
        @(negedge clk);

        // single sample on channel 1, latency of 2 edges
        base0 = byte_q0.size();
        bus0.adc_ack = 2'b10; bus0.dout_adc = 6'h2A;
        @(negedge clk); check("lat_k0_wreq", 32'(bus0.wreq), 32'd0);
        @(negedge clk); check("lat_k1_wreq", 32'(bus0.wreq), 32'd0);
        @(negedge clk); check("lat_k2_wreq", 32'(bus0.wreq), 32'd1);
        check("single_wdata", 32'(bus0.wdata), 32'h6A);
        @(negedge clk); check("single_wreq_1cyc", 32'(bus0.wreq), 32'd0);
        check("single_wdata_hold", 32'(bus0.wdata), 32'h6A);
        bus0.adc_ack = 2'b00;
        repeat (10) @(negedge clk);
        check("single_count", 32'(byte_q0.size() - base0), 32'd1);

        // held ack produces one sample
        base0 = byte_q0.size();
        bus0.adc_ack = 2'b01; bus0.dout_adc = 6'h15;
        repeat (20) @(negedge clk);
        bus0.adc_ack = 2'b00;
        repeat (8) @(negedge clk);
        check("held_count", 32'(byte_q0.size() - base0), 32'd1);
        check("held_byte",  32'(byte_q0[base0]), 32'h15);

        // simultaneous rise: higher channel only
        base0 = byte_q0.size();
        bus0.adc_ack = 2'b11; bus0.dout_adc = 6'h3F;
        repeat (5) @(negedge clk);
        bus0.adc_ack = 2'b00;
        repeat (10) @(negedge clk);
        check("simul_count", 32'(byte_q0.size() - base0), 32'd1);
        check("simul_byte",  32'(byte_q0[base0]), 32'h7F);

        // overflow with the UART busy
        bus0.uart_rdy = 1'b0;
        base0 = byte_q0.size();
        for (int i = 1; i <= 6; i++) begin
            bus0.adc_ack = 2'b01; bus0.dout_adc = 6'(i);
            @(negedge clk);
            if (i == 3) check("ovf_full_after3", 32'(bus0.fifo_full), 32'd0);
            if (i == 4) begin
                check("ovf_full_after4", 32'(bus0.fifo_full), 32'd1);
                check("ovf_flag_after4", 32'(bus0.ovf), 32'd0);
            end
            if (i == 5) check("ovf_flag_after5", 32'(bus0.ovf), 32'd1);
            bus0.adc_ack = 2'b00;
            @(negedge clk);
        end
`ifdef GIRAFFE_PACKER_DROPCNT_EN
        check("ovf_dropcnt", 32'(bus0.drop_cnt), 32'd2);
`endif
        check("ovf_no_tx", 32'(byte_q0.size() - base0), 32'd0);
        bus0.uart_rdy = 1'b1;
        repeat (40) @(negedge clk);
        check("ovf_tx_count", 32'(byte_q0.size() - base0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (byte_q0.size() > base0 + i)
                check("ovf_tx_byte", 32'(byte_q0[base0 + i]), 32'(i + 1));
            else
                check("ovf_tx_missing", 32'd0, 32'd1);
        end
        check("ovf_full_drained", 32'(bus0.fifo_full), 32'd0);
        check("ovf_sticky", 32'(bus0.ovf), 32'd1);

        // multi-byte word on the 12-bit instance
        bus1.adc_ack = 2'b10; bus1.dout_adc = 12'hABC;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus1.wreq === 1'b1) got = 1'b1;
        end
        check("mb_first_seen", 32'(got), 32'd1);
        check("mb_first_byte", 32'(bus1.wdata), 32'h1A);
        t1 = cyc;
        bus1.uart_rdy = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus1.wreq === 1'b1) seen++;
        end
        check("mb_waits_rdy", 32'(seen), 32'd0);
        bus1.uart_rdy = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus1.wreq === 1'b1) got = 1'b1;
        end
        check("mb_second_seen", 32'(got), 32'd1);
        check("mb_second_byte", 32'(bus1.wdata), 32'hBC);
        check("mb_spacing_ge4", 32'((cyc - t1) >= 4), 32'd1);
        bus1.adc_ack = 2'b00;
        repeat (10) @(negedge clk);

        // reset during GAP with a second word queued
        bus1.adc_ack = 2'b10; bus1.dout_adc = 12'hABC;
        @(negedge clk);
        bus1.adc_ack = 2'b11; bus1.dout_adc = 12'h123;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus1.wreq === 1'b1) got = 1'b1;
        end
        check("rmt_first_seen", 32'(got), 32'd1);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rmt_wreq",  32'(bus1.wreq), 32'd0);
        check("rmt_wdata", 32'(bus1.wdata), 32'd0);
        check("rmt_full",  32'(bus1.fifo_full), 32'd0);
        check("rmt_ovf0",  32'(bus0.ovf), 32'd0);
`ifdef GIRAFFE_PACKER_DROPCNT_EN
        check("rmt_dropcnt0", 32'(bus0.drop_cnt), 32'd0);
`endif
        bus1.adc_ack = 2'b00;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        base0 = byte_q0.size();
        base1 = byte_q1.size();
        repeat (20) @(negedge clk);
        check("rmt_no_tx1", 32'(byte_q1.size() - base1), 32'd0);
        check("rmt_no_tx0", 32'(byte_q0.size() - base0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
